// File: rtl/vga_timing_pkg.sv
// Shared timing constants and types for the 640x480@60 Hz raster generator.
// The module parameters default to these values.
package vga_timing_pkg;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int DEF_H_TOTAL =
        DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL =
        DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    localparam int DEF_HS_START = DEF_H_VISIBLE + DEF_H_FRONT;
    localparam int DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;
    localparam int DEF_VS_START = DEF_V_VISIBLE + DEF_V_FRONT;
    localparam int DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;

    typedef logic [9:0] coord_t;

    localparam logic HS_IDLE    = 1'b1;
    localparam logic VS_IDLE    = 1'b1;
    localparam logic BLANK_IDLE = 1'b0;

    localparam logic [2:0] SYNC_IDLE = {HS_IDLE, VS_IDLE, BLANK_IDLE};

    // Half-open interval test: lo <= v < hi
    function automatic logic in_range(coord_t v, int lo, int hi);
        return (int'(v) >= lo) && (int'(v) < hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_sig_delay.sv
// Fixed-depth shift register with a synchronous reset value.
// A depth of zero degenerates to a plain wire.
module sig_delay #(
    parameter int         W       = 1,
    parameter int         DEPTH   = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    if (DEPTH == 0) begin : g_wire
        assign q_o = d_i;
    end else begin : g_pipe
        logic [W-1:0] stage_q [DEPTH];

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= RST_VAL;
                end
            end else begin
                stage_q[0] <= d_i;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign q_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: counters, registered sync/blank/coordinate decode,
// frame/line strobes and a delayed sync copy aligned to the colour path.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE  = DEF_H_VISIBLE,
    parameter int H_FRONT    = DEF_H_FRONT,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BACK     = DEF_H_BACK,
    parameter int V_VISIBLE  = DEF_V_VISIBLE,
    parameter int V_FRONT    = DEF_V_FRONT,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BACK     = DEF_V_BACK,
    parameter int PIPE_DELAY = 1
) (
    input  logic        vga_clk,
    input  logic        reset,
    output logic        hs,
    output logic        vs,
    output logic        blank,
    output logic        sync,
    output coord_t      DrawX,
    output coord_t      DrawY,
    output logic        hs_d,
    output logic        vs_d,
    output logic        blank_d,
    output logic        line_start,
    output logic        frame_start,
    output logic        vblank_tick,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);

    // run_q holds the counters for one cycle after reset release
    logic        run_q,   run_d;
    coord_t      hc_q,    hc_d;
    coord_t      vc_q,    vc_d;
    logic [15:0] fc_q,    fc_d;

    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        act_q,   act_d;
    coord_t      x_q,     x_d;
    coord_t      y_q,     y_d;
    logic        ls_q,    ls_d;
    logic        fs_q,    fs_d;
    logic        vt_q,    vt_d;
    logic [15:0] fcnt_q,  fcnt_d;

    logic h_wrap;
    logic v_wrap;

    assign h_wrap = (hc_q == H_LAST);
    assign v_wrap = (vc_q == V_LAST);

    always_comb begin
        run_d = 1'b1;
        hc_d  = hc_q;
        vc_d  = vc_q;
        fc_d  = fc_q;
        if (run_q) begin
            hc_d = h_wrap ? '0 : hc_q + coord_t'(1);
            if (h_wrap) begin
                vc_d = v_wrap ? '0 : vc_q + coord_t'(1);
                if (v_wrap) begin
                    fc_d = fc_q + 16'd1;
                end
            end
        end
    end

    always_comb begin
        hsync_d = HS_IDLE;
        vsync_d = VS_IDLE;
        act_d   = BLANK_IDLE;
        x_d     = '0;
        y_d     = '0;
        ls_d    = 1'b0;
        fs_d    = 1'b0;
        vt_d    = 1'b0;
        fcnt_d  = fc_q;
        if (run_q) begin
            hsync_d = !in_range(hc_q, HS_START, HS_END);
            vsync_d = !in_range(vc_q, VS_START, VS_END);
            act_d   = in_range(hc_q, 0, H_VISIBLE)
                    && in_range(vc_q, 0, V_VISIBLE);
            x_d     = hc_q;
            y_d     = vc_q;
            ls_d    = (hc_q == '0);
            fs_d    = (hc_q == '0) && (vc_q == '0);
            vt_d    = (hc_q == '0)
                    && (vc_q == coord_t'(V_VISIBLE));
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            run_q   <= 1'b0;
            hc_q    <= '0;
            vc_q    <= '0;
            fc_q    <= '0;
            hsync_q <= HS_IDLE;
            vsync_q <= VS_IDLE;
            act_q   <= BLANK_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
            vt_q    <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            run_q   <= run_d;
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            fc_q    <= fc_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            act_q   <= act_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
            vt_q    <= vt_d;
            fcnt_q  <= fcnt_d;
        end
    end

    logic [2:0] dly;

    sig_delay #(
        .W       (3),
        .DEPTH   (PIPE_DELAY),
        .RST_VAL (SYNC_IDLE)
    ) u_dly (
        .clk_i (vga_clk),
        .rst_i (reset),
        .d_i   ({hsync_q, vsync_q, act_q}),
        .q_o   (dly)
    );

    assign {hs_d, vs_d, blank_d} = dly;

    assign hs          = hsync_q;
    assign vs          = vsync_q;
    assign blank       = act_q;
    assign sync        = 1'b0;
    assign DrawX       = x_q;
    assign DrawY       = y_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
    assign vblank_tick = vt_q;
    assign frame_count = fcnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default-timing line checks plus two reduced-timing
// instances (delay 1 and 3) for frame, rollover and reset checks.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #20 clk = ~clk;

    logic d_hs, d_vs, d_bl, d_sy, d_hsd, d_vsd, d_bld, d_ls, d_fs, d_vt;
    logic a_hs, a_vs, a_bl, a_sy, a_hsd, a_vsd, a_bld, a_ls, a_fs, a_vt;
    logic b_hs, b_vs, b_bl, b_sy, b_hsd, b_vsd, b_bld, b_ls, b_fs, b_vt;
    logic [9:0]  d_x, d_y, a_x, a_y, b_x, b_y;
    logic [15:0] d_fc, a_fc, b_fc;

    vga_timing_gen u_def (
        .vga_clk(clk), .reset(rst),
        .hs(d_hs), .vs(d_vs), .blank(d_bl), .sync(d_sy),
        .DrawX(d_x), .DrawY(d_y),
        .hs_d(d_hsd), .vs_d(d_vsd), .blank_d(d_bld),
        .line_start(d_ls), .frame_start(d_fs), .vblank_tick(d_vt),
        .frame_count(d_fc)
    );

    // Reduced raster: 16 x 10 total, 8 x 6 visible, 160 cycles per frame
    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .PIPE_DELAY(1)
    ) u_r1 (
        .vga_clk(clk), .reset(rst),
        .hs(a_hs), .vs(a_vs), .blank(a_bl), .sync(a_sy),
        .DrawX(a_x), .DrawY(a_y),
        .hs_d(a_hsd), .vs_d(a_vsd), .blank_d(a_bld),
        .line_start(a_ls), .frame_start(a_fs), .vblank_tick(a_vt),
        .frame_count(a_fc)
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .PIPE_DELAY(3)
    ) u_r3 (
        .vga_clk(clk), .reset(rst),
        .hs(b_hs), .vs(b_vs), .blank(b_bl), .sync(b_sy),
        .DrawX(b_x), .DrawY(b_y),
        .hs_d(b_hsd), .vs_d(b_vsd), .blank_d(b_bld),
        .line_start(b_ls), .frame_start(b_fs), .vblank_tick(b_vt),
        .frame_count(b_fc)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {hs, vs, blank} of the reduced raster at output cycle n
    function automatic logic [2:0] rmodel(input int n);
        int x;
        int y;
        if (n < 0) return 3'b110;
        x = n % 16;
        y = (n / 16) % 10;
        return {!(x >= 10 && x < 13), !(y >= 7 && y < 9), (x < 8 && y < 6)};
    endfunction

    localparam logic [9:0] IDLE_BITS = 10'b1100110000;

    task automatic idle3(input string tag);
        chk({tag, "_def_bits"},
            {d_hs, d_vs, d_bl, d_sy, d_hsd, d_vsd, d_bld, d_ls, d_fs, d_vt},
            IDLE_BITS);
        chk({tag, "_def_xyf"}, {d_x, d_y, d_fc}, 0);
        chk({tag, "_r1_bits"},
            {a_hs, a_vs, a_bl, a_sy, a_hsd, a_vsd, a_bld, a_ls, a_fs, a_vt},
            IDLE_BITS);
        chk({tag, "_r1_xyf"}, {a_x, a_y, a_fc}, 0);
        chk({tag, "_r3_bits"},
            {b_hs, b_vs, b_bl, b_sy, b_hsd, b_vsd, b_bld, b_ls, b_fs, b_vt},
            IDLE_BITS);
        chk({tag, "_r3_xyf"}, {b_x, b_y, b_fc}, 0);
    endtask

    task automatic start3(input string tag);
        chk({tag, "_def"}, {d_x, d_y, d_fc, d_bl, d_ls, d_fs, d_hs, d_vs},
            {36'd0, 5'b11111});
        chk({tag, "_r1"}, {a_x, a_y, a_fc, a_bl, a_ls, a_fs, a_hs, a_vs},
            {36'd0, 5'b11111});
        chk({tag, "_r3"}, {b_x, b_y, b_fc, b_bl, b_ls, b_fs, b_hs, b_vs},
            {36'd0, 5'b11111});
    endtask

    int x, y;
    int hs_fall_x = -1, hs_rise_x = -1, bl_fall_x = -1;
    int hs_low = 0, ls_cnt = 0;
    logic prev_hs = 1'b1, prev_bl = 1'b1;
    int bl_f0 = 0, bl_f1 = 0, vt_f0 = 0, vt_f1 = 0, vs_f0 = 0;
    int last_fs = 0;

    initial begin
        rst = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        idle3("in_reset");
        rst = 1'b0;
        @(negedge clk);
        idle3("rel_edge1");
        @(negedge clk);
        start3("rel_edge2");

        for (int n = 0; n < 900; n++) begin
            if (n != 0) @(negedge clk);
            x = n % 16;
            y = (n / 16) % 10;

            chk("r1_x", a_x, x);
            chk("r1_y", a_y, y);
            chk("r1_hvb", {a_hs, a_vs, a_bl}, rmodel(n));
            chk("r1_pulse", {a_ls, a_fs, a_vt},
                {x == 0, x == 0 && y == 0, x == 0 && y == 6});
            chk("r1_fc", a_fc, n / 160);
            chk("r1_dly", {a_hsd, a_vsd, a_bld}, rmodel(n - 1));
            chk("r3_xy", {b_x, b_y}, {10'(x), 10'(y)});
            chk("r3_hvb", {b_hs, b_vs, b_bl}, rmodel(n));
            chk("r3_dly", {b_hsd, b_vsd, b_bld}, rmodel(n - 3));

            if (n < 160) begin
                bl_f0 += a_bl;
                vt_f0 += a_vt;
                vs_f0 += !a_vs;
            end else if (n < 320) begin
                bl_f1 += a_bl;
                vt_f1 += a_vt;
            end
            if (a_fs && n > 0) begin
                chk("r1_fs_period", n - last_fs, 160);
                last_fs = n;
            end

            chk("def_xy", {d_x, d_y}, {10'(n % 800), 10'(n / 800)});
            if (n < 800) begin
                if (prev_hs && !d_hs) hs_fall_x = d_x;
                if (!prev_hs && d_hs) hs_rise_x = d_x;
                if (prev_bl && !d_bl) bl_fall_x = d_x;
                hs_low += !d_hs;
            end
            if (n <= 800) ls_cnt += d_ls;
            if (n == 800) chk("def_ls_800", d_ls, 1);
            prev_hs = d_hs;
            prev_bl = d_bl;
        end

        chk("def_hs_fall", hs_fall_x, 656);
        chk("def_hs_rise", hs_rise_x, 752);
        chk("def_bl_fall", bl_fall_x, 640);
        chk("def_hs_low", hs_low, 96);
        chk("def_ls_cnt", ls_cnt, 2);
        chk("r1_bl_f0", bl_f0, 48);
        chk("r1_bl_f1", bl_f1, 48);
        chk("r1_vt_f0", vt_f0, 1);
        chk("r1_vt_f1", vt_f1, 1);
        chk("r1_vs_low", vs_f0, 32);
        chk("r1_fs_last", last_fs, 800);

        // Preload the frame counter just below rollover
        @(negedge clk);
        force u_r1.fc_q = 16'hFFFF;
        repeat (2) @(negedge clk);
        release u_r1.fc_q;
        @(negedge clk);
        chk("roll_pre", a_fc, 16'hFFFF);
        repeat (56) @(negedge clk);
        chk("roll_hold", {a_fc, a_fs}, {16'hFFFF, 1'b0});
        @(negedge clk);
        chk("roll_wrap", {a_fc, a_fs}, {16'h0000, 1'b1});
        chk("r3_fc_960", {b_fc, b_fs}, {16'd6, 1'b1});

        // Reset in the middle of a frame
        repeat (53) @(negedge clk);
        chk("mid_pos", {a_x, a_y, b_x, b_y}, {10'd5, 10'd3, 10'd5, 10'd3});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle3("mid_rst");
        @(negedge clk);
        idle3("mid_rel1");
        @(negedge clk);
        start3("mid_rel2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
